int2flt32: RTL and testbench

Pipelined signed 32-bit integer to IEEE-754 single-precision converter, the inverse of the float-to-int32 unit in the C2 backend's hardware FP datapath. It accepts one two's-complement operand per cycle and produces a correctly rounded binary32 result. Rounding is round-to-nearest-even. Latency is fixed at 3 cycles, with a global stall input so it can sit in the same issue pipeline as the other FP units.

---
 rtl/int2flt32.sv | 104 ++++++++++
 tb/tb_int2flt32.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/int2flt32.sv
`default_nettype none
// ============================================================================
// Module   : int2flt32
// Purpose  : 3-stage signed int32 -> IEEE-754 binary32 converter, round-to-nearest-even.
// Revision : 1.0  initial release
// ============================================================================
module int2flt32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        a_valid,
  input  logic [31:0] a,
  output logic        z_valid,
  output logic [31:0] z
);

  // Stage 1: sign / magnitude split
  logic        r_s1_s;
  logic [31:0] r_s1_mag;
  logic        r_s1_zero;
  logic        r_s1_v;

  // Stage 2: normalised fraction (leading one dropped) and biased exponent
  logic        r_s2_s;
  logic [30:0] r_s2_frac;
  logic [7:0]  r_s2_exp;
  logic        r_s2_zero;
  logic        r_s2_v;

  // Stage 3: output registers
  logic [31:0] r_z;
  logic        r_z_valid;

  logic [31:0] w_mag;
  logic [4:0]  w_lz;
  logic [30:0] w_frac;
  logic [7:0]  w_exp;
  logic [22:0] w_mant;
  logic        w_g;
  logic        w_st;
  logic        w_round_up;
  logic [23:0] w_sum;
  logic [7:0]  w_exp_r;
  logic [31:0] w_res;

  // Two's-complement negation of -2^31 wraps to 32'h80000000, the correct magnitude.
  assign w_mag = a[31] ? (~a + 32'd1) : a;

  always_comb begin
    w_lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (r_s1_mag[i]) w_lz = 5'(31 - i);
    end
  end

  // The leading one is implicit in binary32, so only the 31 bits below it are kept.
  // The biased exponent spans 127..158 and always fits in 8 bits.
  assign w_frac = 31'(r_s1_mag << w_lz);
  assign w_exp  = 8'd158 - {3'b000, w_lz};

  assign w_mant     = r_s2_frac[30:8];
  assign w_g        = r_s2_frac[7];
  assign w_st       = |r_s2_frac[6:0];
  assign w_round_up = w_g & (w_st | w_mant[0]);
  assign w_sum      = {1'b0, w_mant} + {23'd0, w_round_up};
  assign w_exp_r    = r_s2_exp + {7'd0, w_sum[23]};
  assign w_res      = r_s2_zero ? 32'h00000000 : {r_s2_s, w_exp_r, w_sum[22:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_s    <= 1'b0;
      r_s1_mag  <= 32'd0;
      r_s1_zero <= 1'b0;
      r_s1_v    <= 1'b0;
      r_s2_s    <= 1'b0;
      r_s2_frac <= 31'd0;
      r_s2_exp  <= 8'd0;
      r_s2_zero <= 1'b0;
      r_s2_v    <= 1'b0;
      r_z       <= 32'd0;
      r_z_valid <= 1'b0;
    end else if (en) begin
      r_s1_s    <= a[31];
      r_s1_mag  <= w_mag;
      r_s1_zero <= (a == 32'd0);
      r_s1_v    <= a_valid;

      r_s2_s    <= r_s1_s;
      r_s2_frac <= w_frac;
      r_s2_exp  <= w_exp;
      r_s2_zero <= r_s1_zero;
      r_s2_v    <= r_s1_v;

      // z retains the last valid result across bubbles.
      if (r_s2_v) r_z <= w_res;
      r_z_valid <= r_s2_v;
    end
  end

  assign z       = r_z;
  assign z_valid = r_z_valid;

endmodule
`default_nettype wire

// File: tb/tb_int2flt32.sv
`default_nettype none
// ============================================================================
// Module   : tb_int2flt32
// Purpose  : Self-checking bench for int2flt32 against an arithmetic RNE model.
// Revision : 1.0  initial release
// ============================================================================
module tb_int2flt32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        a_valid = 1'b0;
  logic [31:0] a = 32'd0;
  logic        z_valid;
  logic [31:0] z;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference timing: operands accepted on advancing edges, oldest at index 0.
  logic        pipe_v   [2];
  logic [31:0] pipe_val [2];
  logic        exp_zv = 1'b0;
  logic [31:0] exp_z  = 32'd0;

  int_probe: assert property (@(posedge clk) 1'b1);

  int2flt32 dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a_valid (a_valid),
    .a       (a),
    .z_valid (z_valid),
    .z       (z)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  // Exact integer-to-float conversion with round-to-nearest-even, plain arithmetic.
  function automatic logic [31:0] ref_conv(input logic [31:0] x);
    longint v, m, q, rem, half;
    int p, sh, e;
    logic s;
    logic [63:0] qb;
    v = longint'($signed(x));
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) return 32'h00000000;
    p = 0;
    for (int i = 0; i < 32; i++) if (((m >> i) & 64'd1) != 0) p = i;
    e = p;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e = e + 1;
      end
    end
    qb = 64'(q);
    return {s, 8'(e + 127), qb[22:0]};
  endfunction

  // One clock: drive at negedge, update reference at posedge, compare 1 ns later.
  task automatic step(input logic r, input logic e, input logic av, input logic [31:0] av_a);
    @(negedge clk);
    rst = r; en = e; a_valid = av; a = av_a;
    @(posedge clk);
    if (r) begin
      pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
      pipe_val[0] = 32'd0; pipe_val[1] = 32'd0;
      exp_zv = 1'b0; exp_z = 32'd0;
    end else if (e) begin
      exp_zv = pipe_v[1];
      if (pipe_v[1]) exp_z = pipe_val[1];
      pipe_v[1] = pipe_v[0]; pipe_val[1] = pipe_val[0];
      pipe_v[0] = av;        pipe_val[0] = ref_conv(av_a);
    end
    #1;
    check32("zv", {31'd0, z_valid}, {31'd0, exp_zv});
    check32("z", z, exp_z);
  endtask

  task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] want);
    step(1'b0, 1'b1, 1'b1, x);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    check32({tag, "_v"}, {31'd0, z_valid}, 32'd1);
    check32(tag, z, want);
  endtask

  initial begin
    logic [31:0] got_q[$];
    logic [31:0] r;
    int sel;

    pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
    pipe_val[0] = 32'd0; pipe_val[1] = 32'd0;

    step(1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    check32("rst_z", z, 32'd0);
    check32("rst_zv", {31'd0, z_valid}, 32'd0);

    directed("one",     32'd1,          32'h3F800000);
    directed("neg_one", 32'hFFFFFFFF,   32'hBF800000);
    directed("zero",    32'd0,          32'h00000000);
    directed("min_int", 32'h80000000,   32'hCF000000);
    directed("max_int", 32'h7FFFFFFF,   32'h4F000000);
    directed("hundred", 32'd100,        32'h42C80000);
    directed("tie_dn",  32'd16777217,   32'h4B800000);
    directed("tie_up",  32'd16777219,   32'h4B800002);
    directed("exact",   32'd16777218,   32'h4B800001);
    directed("neg_tie", -32'sd16777219, 32'hCB800002);

    // Streaming with a 2-cycle stall after the second operand.
    step(1'b0, 1'b1, 1'b1, 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'd2);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 32'd3);
      if (z_valid) got_q.push_back(z);
    end
    step(1'b0, 1'b1, 1'b1, 32'd3);
    if (z_valid) got_q.push_back(z);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      if (z_valid) got_q.push_back(z);
    end
    check32("stream_cnt", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check32("stream0", got_q[0], 32'h3F800000);
      check32("stream1", got_q[1], 32'h40000000);
      check32("stream2", got_q[2], 32'h40400000);
    end

    // Reset one cycle after issuing an operand: it must never emerge.
    step(1'b0, 1'b1, 1'b1, 32'd5);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'd0);
      check32("mid_rst_zv", {31'd0, z_valid}, 32'd0);
      check32("mid_rst_z", z, 32'd0);
    end
    directed("after_rst", 32'd7, 32'h40E00000);

    // Random operands with random valid, stall and rare reset.
    for (int i = 0; i < 20000; i++) begin
      sel = $urandom_range(0, 7);
      r = $urandom;
      case (sel)
        0: r = r >> $urandom_range(0, 31);
        1: r = 32'($signed(r) >>> $urandom_range(0, 31));
        2: r = {r[31], 31'd0} | 32'($urandom_range(0, 3));
        3: r = (32'd1 << $urandom_range(0, 31)) + 32'($urandom_range(0, 2)) - 32'd1;
        default: ;
      endcase
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 7), r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
